// File: rtl/ahb_lite_csr_bridge_if.sv
// AHB-Lite slave bus plus CSR register port, bundled for the bridge.
interface ahb_lite_csr_bridge_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;
    logic [31:0] reg_addr;
    logic [31:0] reg_din;
    logic        reg_we;
    logic        reg_re;
    logic [31:0] reg_dout;

    // Bridge side: answers AHB, initiates register accesses.
    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY, reg_dout,
        output HREADYOUT, HRESP, HRDATA, reg_addr, reg_din, reg_we, reg_re
    );

    // Environment side: AHB master plus CSR block.
    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY, reg_dout,
        input  HREADYOUT, HRESP, HRDATA, reg_addr, reg_din, reg_we, reg_re
    );
endinterface

// File: rtl/ahb_lite_csr_bridge.sv
// AHB-Lite to CSR bridge: single-cycle writes, wait-stated reads,
// two-cycle ERROR response for out-of-range or non-word accesses.
module ahb_lite_csr_bridge #(
    parameter int unsigned ADDR_LO   = 1,
    parameter int unsigned ADDR_HI   = 5,
    parameter int unsigned READ_WAIT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    ahb_lite_csr_bridge_if.slave  bus
);

    localparam int unsigned CNT_W = 3;
    localparam int unsigned IDX_W = 30;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD_WAIT,
        RD_DONE,
        ERR1,
        ERR2
    } state_t;

    state_t             state_q;
    logic               hreadyout_q;
    logic               hresp_q;
    logic               reg_we_q;
    logic               reg_re_q;
    logic [31:0]        hrdata_q;
    logic [31:0]        reg_addr_q;
    logic [31:0]        reg_din_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [IDX_W-1:0]   idx_c;
    logic               accept_c;
    logic               legal_c;
    logic               unused_ok;

    // Address-phase decode; a new transfer is only taken while we are ready.
    assign idx_c    = bus.HADDR[31:2];
    assign accept_c = bus.HSEL & bus.HREADY & bus.HTRANS[1] & hreadyout_q;
    assign legal_c  = (idx_c >= IDX_W'(ADDR_LO)) && (idx_c <= IDX_W'(ADDR_HI))
                      && (bus.HSIZE == 3'b010);
    assign unused_ok = &{1'b0, bus.HADDR[1:0], bus.HTRANS[0]};

    // Transfer FSM with registered bus and strobe outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
            reg_we_q    <= 1'b0;
            reg_re_q    <= 1'b0;
            hrdata_q    <= 32'd0;
            reg_addr_q  <= 32'd0;
            reg_din_q   <= 32'd0;
            cnt_q       <= '0;
        end else begin
            reg_we_q <= 1'b0;
            reg_re_q <= 1'b0;
            if (state_q == WR) begin
                reg_din_q <= bus.HWDATA;
            end
            case (state_q)
                RD_WAIT: begin
                    if (cnt_q == '0) begin
                        hrdata_q    <= bus.reg_dout;
                        state_q     <= RD_DONE;
                        hreadyout_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ERR1: begin
                    state_q     <= ERR2;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= 1'b1;
                end
                default: begin
                    if (accept_c && !legal_c) begin
                        state_q     <= ERR1;
                        hreadyout_q <= 1'b0;
                        hresp_q     <= 1'b1;
                    end else if (accept_c && bus.HWRITE) begin
                        state_q     <= WR;
                        reg_we_q    <= 1'b1;
                        reg_addr_q  <= {2'b00, idx_c};
                        hreadyout_q <= 1'b1;
                        hresp_q     <= 1'b0;
                    end else if (accept_c) begin
                        state_q     <= RD_WAIT;
                        reg_re_q    <= 1'b1;
                        reg_addr_q  <= {2'b00, idx_c};
                        hreadyout_q <= 1'b0;
                        hresp_q     <= 1'b0;
                        cnt_q       <= CNT_W'(READ_WAIT - 1);
                    end else begin
                        state_q     <= IDLE;
                        hreadyout_q <= 1'b1;
                        hresp_q     <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Write data passes straight through during WR, otherwise the last write is held.
    assign bus.reg_din   = (state_q == WR) ? bus.HWDATA : reg_din_q;
    assign bus.HREADYOUT = hreadyout_q;
    assign bus.HRESP     = hresp_q;
    assign bus.HRDATA    = hrdata_q;
    assign bus.reg_addr  = reg_addr_q;
    assign bus.reg_we    = reg_we_q;
    assign bus.reg_re    = reg_re_q;

endmodule
